sram_arbiter: RTL and testbench

//  Shares one external 16-bit async SRAM (CE/OE/WR/UB/LB, active-low) between two requesters.

---
 rtl/sram_arbiter_if.sv | 23 ++
 rtl/sram_arbiter.sv | 116 +++++++++++
 tb/tb_sram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two packed requester lanes {r1, r0}
// plus the shared read-data return and one-hot completion pulse.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic [1:0]          req;
  logic [1:0]          we;
  logic [3:0]          be;
  logic [2*ADDR_W-1:0] addr;
  logic [31:0]         wdata;
  logic [15:0]         rdata;
  logic [1:0]          ack;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for one external 16-bit async SRAM: picks a requester, latches its
// command and sequences the active-low CE/OE/WR/UB/LB strobes through SETUP/ACCESS/DONE.
module sram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int FIXED_PRIO    = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  output logic              sram_doe,
  input  logic [15:0]       sram_din,
  output logic              CE,
  output logic              OE,
  output logic              WR,
  output logic              UB,
  output logic              LB
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              grant;
  logic              last_grant;
  logic              win;
  logic              cmd_we;
  logic [1:0]        cmd_be;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_wdata;
  logic [15:0]       rdata_q;
  logic [1:0]        ack;

  // A sole requester always wins; a tie goes to the fixed favourite or to whoever did not go last.
  always_comb begin
    case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command is captured once at grant so later bus changes cannot disturb the SRAM cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cmd_we     <= 1'b0;
      cmd_be     <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && |bus.req) begin
        grant      <= win;
        last_grant <= win;
        cmd_we     <= bus.we[win];
        cmd_be     <= win ? bus.be[3:2] : bus.be[1:0];
        cmd_addr   <= win ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
        cmd_wdata  <= win ? bus.wdata[31:16] : bus.wdata[15:0];
      end
      if (state == SETUP)       cnt <= CNT_W'(ACCESS_CYCLES);
      else if (state == ACCESS) cnt <= cnt - 1'b1;
      if (state == ACCESS && cnt == CNT_W'(1) && !cmd_we) rdata_q <= sram_din;
    end
  end

  // DONE keeps CE, byte lanes and write data driven so the SRAM sees hold time after WR rises.
  always_comb begin
    CE        = 1'b1;
    OE        = 1'b1;
    WR        = 1'b1;
    UB        = 1'b1;
    LB        = 1'b1;
    sram_doe  = 1'b0;
    sram_addr = '0;
    sram_dout = '0;
    ack       = 2'b00;
    if (state != IDLE) begin
      CE        = 1'b0;
      UB        = ~cmd_be[1];
      LB        = ~cmd_be[0];
      sram_addr = cmd_addr;
      sram_doe  = cmd_we;
      sram_dout = cmd_we ? cmd_wdata : 16'h0000;
      OE        = cmd_we | (state == DONE);
      WR        = ~(cmd_we & (state == ACCESS));
      if (state == DONE) ack = grant ? 2'b10 : 2'b01;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: lane 0 is a default round-robin build, lane 1 a fixed-priority
// ACCESS_CYCLES=1 build, both checked every cycle against a transaction-level model.
module tb_sram_arbiter;
  localparam int ADDR_W = 16;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  req_s   [2];
  logic [1:0]  we_s    [2];
  logic [3:0]  be_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [1:0]  ack_o   [2];
  logic [15:0] rdata_o [2];
  logic [15:0] saddr_o [2];
  logic [15:0] dout_o  [2];
  logic        ce_o [2], oe_o [2], wr_o [2], ub_o [2], lb_o [2], doe_o [2];

  int       ack_cyc [2], oe_lo [2], wr_lo [2], ub_lo [2], lb_lo [2], ce_lo [2];
  int       doe_hi [2], dout_ok [2], addr2_hits [2], nack [2];
  logic [1:0] ack_val [2];
  logic [1:0] got [2];
  logic [7:0] seq [2];

  // SRAM contents as a fixed function of address, with one pinned word.
  function automatic logic [15:0] sram_word(input logic [15:0] a);
    if (a == 16'h1234) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input int lane, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL lane%0d %s: got %h, expected %h at %0t", lane, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int AC = (g == 0) ? 2 : 1;
    localparam int FP = (g == 0) ? 0 : 1;

    sram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dout, sram_din;
    logic              sram_doe, ce, oe, wr, ub, lb;

    sram_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC), .FIXED_PRIO(FP)) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
      .CE(ce), .OE(oe), .WR(wr), .UB(ub), .LB(lb)
    );

    assign sram_din    = sram_word(sram_addr);
    assign bus.req     = req_s[g];
    assign bus.we      = we_s[g];
    assign bus.be      = be_s[g];
    assign bus.addr    = addr_s[g];
    assign bus.wdata   = wdata_s[g];
    assign ack_o[g]    = bus.ack;
    assign rdata_o[g]  = bus.rdata;
    assign saddr_o[g]  = sram_addr;
    assign dout_o[g]   = sram_dout;
    assign ce_o[g]     = ce;
    assign oe_o[g]     = oe;
    assign wr_o[g]     = wr;
    assign ub_o[g]     = ub;
    assign lb_o[g]     = lb;
    assign doe_o[g]    = sram_doe;

    // k = cycles since the grant edge (0 = idle); outputs follow from k and the granted command.
    initial begin : model
      int k, lg, t_g;
      logic t_we;
      logic [1:0] t_be, e_ack;
      logic [15:0] t_addr, t_wdata, e_rdata, e_addr, e_dout;
      logic e_ce, e_oe, e_wr, e_ub, e_lb, e_doe;
      k = 0; lg = 1; t_g = 0; t_we = 1'b0; t_be = 2'b00;
      t_addr = 16'h0; t_wdata = 16'h0; e_rdata = 16'h0;
      forever begin
        @(negedge CLK);
        if (RST_N !== 1'b1) begin
          k = 0; lg = 1; e_rdata = 16'h0;
        end
        if (k == 0) begin
          e_ce = 1'b1; e_oe = 1'b1; e_wr = 1'b1; e_ub = 1'b1; e_lb = 1'b1;
          e_doe = 1'b0; e_addr = 16'h0; e_dout = 16'h0; e_ack = 2'b00;
        end else begin
          e_ce   = 1'b0;
          e_addr = t_addr;
          e_ub   = ~t_be[1];
          e_lb   = ~t_be[0];
          e_doe  = t_we;
          e_dout = t_wdata;
          e_oe   = (!t_we && k <= AC + 1) ? 1'b0 : 1'b1;
          e_wr   = (t_we && k >= 2 && k <= AC + 1) ? 1'b0 : 1'b1;
          e_ack  = (k == AC + 2) ? ((t_g == 1) ? 2'b10 : 2'b01) : 2'b00;
        end
        checkOutput(g, "CE", ce, e_ce);
        checkOutput(g, "OE", oe, e_oe);
        checkOutput(g, "WR", wr, e_wr);
        checkOutput(g, "UB", ub, e_ub);
        checkOutput(g, "LB", lb, e_lb);
        checkOutput(g, "sram_doe", sram_doe, e_doe);
        checkOutput(g, "sram_addr", sram_addr, e_addr);
        checkOutput(g, "ack", bus.ack, e_ack);
        checkOutput(g, "rdata", bus.rdata, e_rdata);
        if (e_doe || k == 0) checkOutput(g, "sram_dout", sram_dout, e_dout);
        if (RST_N === 1'b1) begin
          if (k == 0) begin
            if (req_s[g] != 2'b00) begin
              if (req_s[g] == 2'b01)      t_g = 0;
              else if (req_s[g] == 2'b10) t_g = 1;
              else                        t_g = (FP != 0) ? 1 : 1 - lg;
              lg      = t_g;
              t_we    = we_s[g][t_g];
              t_be    = be_s[g][2*t_g +: 2];
              t_addr  = addr_s[g][16*t_g +: 16];
              t_wdata = wdata_s[g][16*t_g +: 16];
              k = 1;
            end
          end else if (k == AC + 2) begin
            k = 0;
          end else begin
            k++;
            if (k == AC + 2 && !t_we) e_rdata = sram_word(t_addr);
          end
        end
      end
    end
  end

  task automatic randCmd(input int l, input int r);
    we_s[l][r]             = 1'($urandom_range(0, 1));
    be_s[l][2*r +: 2]      = 2'($urandom_range(0, 3));
    addr_s[l][16*r +: 16]  = 16'($urandom);
    wdata_s[l][16*r +: 16] = 16'($urandom);
  endtask

  // Follows one transaction of requester r on both lanes; c = 0 is the IDLE cycle that sees req.
  task automatic watchTxn(input int r, input logic [15:0] addr2, input logic [15:0] wd);
    bit done [2];
    for (int l = 0; l < 2; l++) begin
      done[l] = 1'b0; ack_cyc[l] = -1; ack_val[l] = 2'b00;
      oe_lo[l] = 0; wr_lo[l] = 0; ub_lo[l] = 0; lb_lo[l] = 0; ce_lo[l] = 0;
      doe_hi[l] = 0; dout_ok[l] = 0; addr2_hits[l] = 0;
    end
    for (int c = 0; c <= 12; c++) begin
      @(negedge CLK);
      for (int l = 0; l < 2; l++) begin
        if (!done[l]) begin
          if (!oe_o[l]) oe_lo[l]++;
          if (!wr_o[l]) wr_lo[l]++;
          if (!ub_o[l]) ub_lo[l]++;
          if (!lb_o[l]) lb_lo[l]++;
          if (!ce_o[l]) ce_lo[l]++;
          if (doe_o[l]) doe_hi[l]++;
          if (doe_o[l] && dout_o[l] == wd) dout_ok[l]++;
          if (!ce_o[l] && saddr_o[l] == addr2) addr2_hits[l]++;
          if (ack_o[l] != 2'b00) begin
            ack_cyc[l] = c; ack_val[l] = ack_o[l]; done[l] = 1'b1;
          end
        end
      end
      @(posedge CLK); #1;
      for (int l = 0; l < 2; l++) begin
        if (c == 0) addr_s[l][16*r +: 16] = addr2;
        if (done[l]) req_s[l][r] = 1'b0;
      end
      if (done[0] && done[1]) break;
    end
    for (int l = 0; l < 2; l++) checkOutput(l, "ack seen", 32'(done[l]), 32'd1);
  endtask

  task automatic applyStimulus(input int r, input logic we, input logic [1:0] be,
                               input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] addr2);
    @(posedge CLK); #1;
    for (int l = 0; l < 2; l++) begin
      req_s[l][r]             = 1'b1;
      we_s[l][r]              = we;
      be_s[l][2*r +: 2]       = be;
      addr_s[l][16*r +: 16]   = addr;
      wdata_s[l][16*r +: 16]  = wdata;
    end
    watchTxn(r, addr2, wdata);
  endtask

  initial begin
    RST_N = 1'b0;
    for (int l = 0; l < 2; l++) begin
      req_s[l] = 2'b00; we_s[l] = 2'b00; be_s[l] = 4'h0; addr_s[l] = 32'h0; wdata_s[l] = 32'h0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int l = 0; l < 2; l++) begin
      checkOutput(l, "reset CE", 32'(ce_o[l]), 32'd1);
      checkOutput(l, "reset WR", 32'(wr_o[l]), 32'd1);
      checkOutput(l, "reset doe", 32'(doe_o[l]), 32'd0);
      checkOutput(l, "reset ack", 32'(ack_o[l]), 32'd0);
      checkOutput(l, "reset rdata", 32'(rdata_o[l]), 32'd0);
    end
    @(posedge CLK); #3 RST_N = 1'b1;

    // Read by r0: OE low through SETUP and ACCESS, ack AC+2 cycles after the request.
    applyStimulus(0, 1'b0, 2'b11, 16'h1234, 16'h0000, 16'h1234);
    for (int l = 0; l < 2; l++) begin
      checkOutput(l, "t1 ack cycle", 32'(ack_cyc[l]), 32'(4 - l));
      checkOutput(l, "t1 ack value", 32'(ack_val[l]), 32'h1);
      checkOutput(l, "t1 OE low cycles", 32'(oe_lo[l]), 32'(3 - l));
      checkOutput(l, "t1 CE low cycles", 32'(ce_lo[l]), 32'(4 - l));
      checkOutput(l, "t1 WR low cycles", 32'(wr_lo[l]), 32'd0);
      checkOutput(l, "t1 rdata", 32'(rdata_o[l]), 32'hBEEF);
    end

    // Address changed right after grant must not reach the pins.
    applyStimulus(0, 1'b0, 2'b11, 16'h0001, 16'h0000, 16'h0002);
    for (int l = 0; l < 2; l++) begin
      checkOutput(l, "t5 new addr on pins", 32'(addr2_hits[l]), 32'd0);
      checkOutput(l, "t5 rdata", 32'(rdata_o[l]), 32'hC46D);
    end

    // Lower-byte write by r1.
    applyStimulus(1, 1'b1, 2'b01, 16'h0040, 16'hA5A5, 16'h0040);
    for (int l = 0; l < 2; l++) begin
      checkOutput(l, "t2 WR low cycles", 32'(wr_lo[l]), 32'(2 - l));
      checkOutput(l, "t2 LB low cycles", 32'(lb_lo[l]), 32'(4 - l));
      checkOutput(l, "t2 UB low cycles", 32'(ub_lo[l]), 32'd0);
      checkOutput(l, "t2 doe cycles", 32'(doe_hi[l]), 32'(4 - l));
      checkOutput(l, "t2 dout A5A5 cycles", 32'(dout_ok[l]), 32'(4 - l));
      checkOutput(l, "t2 ack value", 32'(ack_val[l]), 32'h2);
      checkOutput(l, "t2 rdata kept", 32'(rdata_o[l]), 32'hC46D);
    end

    // Read with no byte lanes enabled still runs the full cycle and captures all 16 bits.
    applyStimulus(1, 1'b0, 2'b00, 16'h0300, 16'h0000, 16'h0300);
    for (int l = 0; l < 2; l++) begin
      checkOutput(l, "t6 UB low cycles", 32'(ub_lo[l]), 32'd0);
      checkOutput(l, "t6 LB low cycles", 32'(lb_lo[l]), 32'd0);
      checkOutput(l, "t6 ack cycle", 32'(ack_cyc[l]), 32'(4 - l));
      checkOutput(l, "t6 ack value", 32'(ack_val[l]), 32'h2);
      checkOutput(l, "t6 rdata", 32'(rdata_o[l]), 32'hFF5A);
    end

    // Both requesters held high: round-robin alternates, fixed priority always serves r1.
    @(posedge CLK); #1;
    for (int l = 0; l < 2; l++) begin
      nack[l] = 0; seq[l] = 8'h00; req_s[l] = 2'b11;
      randCmd(l, 0); randCmd(l, 1);
    end
    for (int c = 0; c < 120 && (nack[0] < 8 || nack[1] < 8); c++) begin
      @(negedge CLK);
      for (int l = 0; l < 2; l++) got[l] = ack_o[l];
      @(posedge CLK); #1;
      for (int l = 0; l < 2; l++) begin
        if (got[l] != 2'b00 && nack[l] < 8) begin
          seq[l][nack[l]] = (got[l] == 2'b10);
          nack[l]++;
          if (nack[l] == 8) req_s[l] = 2'b00;
          else              randCmd(l, got[l][1] ? 1 : 0);
        end
      end
    end
    checkOutput(0, "rr ack order", 32'(seq[0]), 32'h000000AA);
    checkOutput(1, "fixed prio ack order", 32'(seq[1]), 32'h000000FF);
    for (int l = 0; l < 2; l++) req_s[l] = 2'b00;
    repeat (2) @(posedge CLK);

    // Reset during the first ACCESS cycle of a write drops it; the held req is served afresh.
    @(posedge CLK); #1;
    for (int l = 0; l < 2; l++) begin
      req_s[l][0] = 1'b1; we_s[l][0] = 1'b1; be_s[l][1:0] = 2'b11;
      addr_s[l][15:0] = 16'h0777; wdata_s[l][15:0] = 16'h1111;
    end
    @(posedge CLK);
    @(posedge CLK); #2;
    for (int l = 0; l < 2; l++) checkOutput(l, "t4 WR low before reset", 32'(wr_o[l]), 32'd0);
    RST_N = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      checkOutput(l, "t4 CE in reset", 32'(ce_o[l]), 32'd1);
      checkOutput(l, "t4 WR in reset", 32'(wr_o[l]), 32'd1);
      checkOutput(l, "t4 OE in reset", 32'(oe_o[l]), 32'd1);
      checkOutput(l, "t4 doe in reset", 32'(doe_o[l]), 32'd0);
      checkOutput(l, "t4 ack in reset", 32'(ack_o[l]), 32'd0);
    end
    @(posedge CLK); #3 RST_N = 1'b1;
    watchTxn(0, 16'h0777, 16'h1111);
    for (int l = 0; l < 2; l++) begin
      checkOutput(l, "t4 ack cycle after reset", 32'(ack_cyc[l]), 32'(4 - l));
      checkOutput(l, "t4 ack value after reset", 32'(ack_val[l]), 32'h1);
      checkOutput(l, "t4 WR low cycles after reset", 32'(wr_lo[l]), 32'(2 - l));
    end

    // Random requesters: new commands, field churn, early drops; the model checks every cycle.
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      for (int l = 0; l < 2; l++) got[l] = ack_o[l];
      @(posedge CLK); #1;
      for (int l = 0; l < 2; l++) begin
        for (int r = 0; r < 2; r++) begin
          if (!req_s[l][r]) begin
            if ($urandom_range(0, 2) == 0) begin
              randCmd(l, r);
              req_s[l][r] = 1'b1;
            end
          end else if (got[l][r]) begin
            if ($urandom_range(0, 1) == 0) req_s[l][r] = 1'b0;
            else                           randCmd(l, r);
          end else begin
            if ($urandom_range(0, 31) == 0)     req_s[l][r] = 1'b0;
            else if ($urandom_range(0, 3) == 0) randCmd(l, r);
          end
        end
      end
    end
    for (int l = 0; l < 2; l++) req_s[l] = 2'b00;
    repeat (8) @(posedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
